sub_bytes_seq: RTL and testbench

//   Forward AES SubBytes engine for the encryption datapath; the encrypt-side

---
 rtl/sub_bytes_seq.sv | 119 +++++++++++
 tb/tb_sub_bytes_seq.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_bytes_seq.sv
// Forward AES SubBytes engine: one 128-bit state per handshake, substituted
// BYTES_PER_CYCLE bytes per cycle through shared SBox instances.
module sub_bytes_seq #(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] din,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] dout,
    output logic         busy
);

    localparam int NCHUNK  = 16 / BYTES_PER_CYCLE;
    localparam int CNT_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int CHUNK_W = 8 * BYTES_PER_CYCLE;

    if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4 &&
        BYTES_PER_CYCLE != 8 && BYTES_PER_CYCLE != 16) begin : g_bpc_check
        $error("sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    // Forward FIPS-197 SBox, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TBL[8 * (255 - int'(x)) +: 8];
    endfunction

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [127:0]         work_q, work_d;
    logic [CHUNK_W-1:0]   chunk_in, chunk_out;
    int                   base;

    always_comb begin
        base     = int'(cnt_q) * CHUNK_W;
        chunk_in = work_q[base +: CHUNK_W];
    end

    for (genvar b = 0; b < BYTES_PER_CYCLE; b++) begin : g_sbox
        assign chunk_out[8*b +: 8] = sbox(chunk_in[8*b +: 8]);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    work_d  = din;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                work_d[base +: CHUNK_W] = chunk_out;
                cnt_d = CNT_W'(cnt_q + 1'b1);
                if (cnt_q == CNT_W'(NCHUNK - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Gate with out_valid so dout reads zero out of reset without resetting the datapath.
        dout = out_valid ? work_q : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        work_q <= work_d;
    end

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Directed bench for sub_bytes_seq at BYTES_PER_CYCLE = 4, 1 and 16,
// with an algebraic (GF(2^8) inverse + affine) SBox model for the sweep.
module tb_sub_bytes_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] din;
    logic [2:0]   iv_v;
    logic [2:0]   or_v;
    logic [2:0]   ir_v;
    logic [2:0]   ov_v;
    logic [2:0]   busy_v;
    logic [127:0] dout_a [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int BPC = (g == 0) ? 4 : ((g == 1) ? 1 : 16);
        sub_bytes_seq #(.BYTES_PER_CYCLE(BPC)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (iv_v[g]),
            .in_ready  (ir_v[g]),
            .din       (din),
            .out_valid (ov_v[g]),
            .out_ready (or_v[g]),
            .dout      (dout_a[g]),
            .busy      (busy_v[g])
        );
    end

    localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] ZERO_IN  = 128'h0;
    localparam logic [127:0] ZERO_OUT = {16{8'h63}};
    localparam logic [127:0] X53_IN   = {16{8'h53}};
    localparam logic [127:0] X53_OUT  = {16{8'hed}};

    function automatic int nch(input int s);
        return (s == 0) ? 4 : ((s == 1) ? 16 : 1);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] model_sbox(input logic [7:0] a);
        logic [7:0] inv = 8'h00;
        if (a != 8'h00) begin
            for (int b = 1; b < 256; b++) begin
                if (gf_mul(a, 8'(b)) == 8'h01) inv = 8'(b);
            end
        end
        return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    endfunction

    task automatic accept_block(input int s, input logic [127:0] d);
        @(negedge clk);
        din     = d;
        iv_v[s] = 1'b1;
        total++;
        if (ir_v[s] !== 1'b1) begin
            bad++;
            $display("FAIL accept_ready inst=%0d got=%b want=1", s, ir_v[s]);
        end
        @(posedge clk);
        #1;
        iv_v[s] = 1'b0;
        din     = ~d;
    endtask

    task automatic wait_done(input int s, output int cyc, output bit seen);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (ov_v[s] === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic run_block(input int s, input logic [127:0] d, input logic [127:0] exp,
                             input string name);
        int cyc;
        bit seen;
        accept_block(s, d);
        wait_done(s, cyc, seen);
        total++;
        if (!seen || cyc != nch(s)) begin
            bad++;
            $display("FAIL %s_latency inst=%0d got=%0d want=%0d", name, s, cyc, nch(s));
        end
        total++;
        if (dout_a[s] !== exp) begin
            bad++;
            $display("FAIL %s_dout inst=%0d got=%h want=%h", name, s, dout_a[s], exp);
        end
        or_v[s] = 1'b1;
        @(posedge clk);
        #1;
        or_v[s] = 1'b0;
        total++;
        if (ov_v[s] !== 1'b0 || ir_v[s] !== 1'b1) begin
            bad++;
            $display("FAIL %s_release inst=%0d got ov=%b ir=%b want ov=0 ir=1",
                     name, s, ov_v[s], ir_v[s]);
        end
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        din  = '0;
        iv_v = '0;
        or_v = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) begin
            total++;
            if (ir_v[s] !== 1'b1 || ov_v[s] !== 1'b0 || busy_v[s] !== 1'b0 || dout_a[s] !== '0) begin
                bad++;
                $display("FAIL reset_state inst=%0d got ir=%b ov=%b busy=%b dout=%h want 1 0 0 0",
                         s, ir_v[s], ov_v[s], busy_v[s], dout_a[s]);
            end
        end
    endtask

    task automatic test_vectors(input int s);
        run_block(s, FIPS_IN, FIPS_OUT, "fips");
        run_block(s, ZERO_IN, ZERO_OUT, "zero");
        run_block(s, X53_IN,  X53_OUT,  "x53");
    endtask

    task automatic test_backpressure(input int s);
        int cyc;
        bit seen;
        bit stable = 1'b1;
        accept_block(s, FIPS_IN);
        wait_done(s, cyc, seen);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 3) begin
                din     = X53_IN;
                iv_v[s] = 1'b1;
            end else begin
                iv_v[s] = 1'b0;
            end
            if (ov_v[s] !== 1'b1 || ir_v[s] !== 1'b0 || busy_v[s] !== 1'b1 ||
                dout_a[s] !== FIPS_OUT) stable = 1'b0;
        end
        @(negedge clk);
        iv_v[s] = 1'b0;
        total++;
        if (!seen || !stable) begin
            bad++;
            $display("FAIL bp_hold inst=%0d got seen=%b stable=%b want 1 1", s, seen, stable);
        end
        or_v[s] = 1'b1;
        @(posedge clk);
        #1;
        or_v[s] = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (ov_v[s] !== 1'b0 || ir_v[s] !== 1'b1 || busy_v[s] !== 1'b0) begin
            bad++;
            $display("FAIL bp_release inst=%0d got ov=%b ir=%b busy=%b want 0 1 0",
                     s, ov_v[s], ir_v[s], busy_v[s]);
        end
    endtask

    task automatic test_reset_mid(input int s);
        accept_block(s, FIPS_IN);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        total++;
        if (ov_v[s] !== 1'b0 || ir_v[s] !== 1'b1 || busy_v[s] !== 1'b0 || dout_a[s] !== '0) begin
            bad++;
            $display("FAIL reset_mid inst=%0d got ov=%b ir=%b busy=%b dout=%h want 0 1 0 0",
                     s, ov_v[s], ir_v[s], busy_v[s], dout_a[s]);
        end
        @(negedge clk);
        rst = 1'b0;
        run_block(s, ZERO_IN, ZERO_OUT, "after_rst");
    endtask

    task automatic test_back_to_back(input int s);
        int acc = 0;
        int got = 0;
        int acc_t [2] = '{0, 0};
        logic [127:0] res [2] = '{128'h0, 128'h0};
        @(negedge clk);
        din     = FIPS_IN;
        iv_v[s] = 1'b1;
        or_v[s] = 1'b1;
        for (int cyc = 0; cyc < 3 * nch(s) + 12; cyc++) begin
            if (ir_v[s] === 1'b1 && iv_v[s] === 1'b1 && acc < 2) begin
                acc_t[acc] = cyc;
                acc++;
            end
            if (ov_v[s] === 1'b1 && got < 2) begin
                res[got] = dout_a[s];
                got++;
            end
            @(posedge clk);
            #1;
            if (acc == 1) din = X53_IN;
            if (acc == 2) iv_v[s] = 1'b0;
            @(negedge clk);
        end
        iv_v[s] = 1'b0;
        or_v[s] = 1'b0;
        total++;
        if (acc != 2 || acc_t[1] - acc_t[0] != nch(s) + 2) begin
            bad++;
            $display("FAIL b2b_spacing inst=%0d got accepts=%0d gap=%0d want 2 %0d",
                     s, acc, acc_t[1] - acc_t[0], nch(s) + 2);
        end
        total++;
        if (got != 2 || res[0] !== FIPS_OUT || res[1] !== X53_OUT) begin
            bad++;
            $display("FAIL b2b_data inst=%0d got n=%0d r0=%h r1=%h want %h %h",
                     s, got, res[0], res[1], FIPS_OUT, X53_OUT);
        end
    endtask

    task automatic test_sweep();
        logic [127:0] d;
        logic [127:0] e;
        for (int blk = 0; blk < 16; blk++) begin
            for (int k = 0; k < 16; k++) begin
                d[8*k +: 8] = 8'(16 * blk + k);
                e[8*k +: 8] = model_sbox(8'(16 * blk + k));
            end
            run_block(2, d, e, "sweep");
        end
    endtask

    initial begin
        test_reset();
        for (int s = 0; s < 3; s++) begin
            test_vectors(s);
            test_backpressure(s);
            test_reset_mid(s);
            test_back_to_back(s);
        end
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
